// File: rtl/uram_arb_pkg.sv
// rtl/uram_arb_pkg.sv - shared types, depth constant and round-robin pick helper for uram_access_arbiter
package uram_arb_pkg;

  localparam int RSP_DEPTH       = 2;
  localparam int RR_MAX          = 8;
  localparam int URAM_DATA_WIDTH = 64;

  typedef struct packed {
    logic [URAM_DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Walks from the highest offset down so the lane closest to ptr is the last (winning) assignment.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid, input logic [2:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       lane;
    r = '0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        lane = (int'(ptr) + k) % n;
        if (valid[lane[2:0]]) begin
          r.found = 1'b1;
          r.idx   = lane[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NUM_REQ round-robin arbiter: combinational grant, pointer advances past the winner
module rr_arbiter
  import uram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  rr_pick_t         pick;

  always_comb begin
    pick        = rr_pick(RR_MAX'(req), 3'(ptr_q), NUM_REQ);
    grant_valid = pick.found;
    grant_idx   = IDX_W'(pick.idx);
    grant       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = pick.found && (pick.idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (pick.found) begin
      ptr_q <= IDX_W'((int'(pick.idx) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/uram_access_arbiter.sv
// rtl/uram_access_arbiter.sv - shares one SDP URAM between NUM_REQ writers and one credited reader
// Optional: define URAM_WR_FWD_EN to forward same-cycle same-address write data to the read.
module uram_access_arbiter
  import uram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = $bits(rsp_entry_t),
  parameter int ADDR_WIDTH = 12,
  parameter int RSP_DEPTH  = uram_arb_pkg::RSP_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_valid,
  output logic [NUM_REQ-1:0]            wr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic [DATA_WIDTH-1:0]         ram_data,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic [DATA_WIDTH-1:0]         ram_out,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (wr_valid & {NUM_REQ{rst_n}}),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign wr_ready = grant;

  always_comb begin
    ram_we    = grant_valid;
    ram_waddr = '0;
    ram_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && grant_idx == IDX_W'(i)) begin
        ram_waddr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data  = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0] rsp_buf [RSP_DEPTH];
  logic                  wptr_q;
  logic                  rptr_q;
  logic [1:0]            count_q;
  logic                  pop;
  logic                  push;
  logic                  rd_fire;
  logic [2:0]            committed;
  logic [DATA_WIDTH-1:0] push_data;

  assign rsp_valid = (count_q != 2'd0);
  assign rsp_data  = rsp_buf[rptr_q];
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight_q;

  // A pop this cycle frees its slot in time for a read issued now, giving 1 read/cycle when drained.
  assign committed = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign rd_ready  = rst_n && (committed < 3'(RSP_DEPTH));
  assign rd_fire   = rd_valid && rd_ready;
  assign ram_raddr = rd_fire ? rd_addr : raddr_q;
  assign busy      = rst_n && ((|wr_valid) || inflight_q || rsp_valid);

`ifdef URAM_WR_FWD_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= rd_fire && ram_we && (ram_waddr == rd_addr);
      fwd_data_q <= ram_data;
    end
  end

  assign push_data = fwd_q ? fwd_data_q : ram_out;
`else
  assign push_data = ram_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      raddr_q    <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      inflight_q <= rd_fire;
      if (rd_fire) raddr_q <= rd_addr;
      if (push) wptr_q <= ~wptr_q;
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) rsp_buf[wptr_q] <= push_data;
  end

  rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'(RSP_DEPTH)));

endmodule
